// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM state type and access-size decode for the load/store unit
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 3'd1 : (sz == 2'd1) ? 3'd2 : (sz == 2'd2) ? 3'd4 : 3'd0;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store data/strobe lane placement and load extract/extend
module lsu_lane_align #(
   parameter int DATA_WIDTH = 32,
   localparam int B = DATA_WIDTH / 8,
   localparam int OW = $clog2(B)
) (
   input  logic [1:0]            i_size,
   input  logic                  i_unsigned,
   input  logic [OW-1:0]         i_off,
   input  logic [31:0]           i_wdata,
   input  logic [DATA_WIDTH-1:0] i_rdata_lo,
   input  logic [DATA_WIDTH-1:0] i_rdata_hi,
   output logic [DATA_WIDTH-1:0] o_data_lo,
   output logic [DATA_WIDTH-1:0] o_data_hi,
   output logic [B-1:0]          o_strb_lo,
   output logic [B-1:0]          o_strb_hi,
   output logic [31:0]           o_rdata
);
   logic [2*DATA_WIDTH-1:0] wide_d;
   logic [2*B-1:0] wide_s;
   logic [31:0] raw;
   always_comb begin
      wide_d = {{(2*DATA_WIDTH-32){1'b0}}, i_wdata} << {i_off, 3'b000};
      wide_s = {{(2*B-4){1'b0}}, (i_size == 2'd0) ? 4'h1 : (i_size == 2'd1) ? 4'h3 : 4'hF} << i_off;
      raw = 32'({i_rdata_hi, i_rdata_lo} >> {i_off, 3'b000});
      o_rdata = (i_size == 2'd0) ? {{24{~i_unsigned & raw[7]}}, raw[7:0]} :
                (i_size == 2'd1) ? {{16{~i_unsigned & raw[15]}}, raw[15:0]} : raw;
   end

   assign o_data_lo = wide_d[DATA_WIDTH-1:0];
   assign o_data_hi = wide_d[2*DATA_WIDTH-1:DATA_WIDTH];
   assign o_strb_lo = wide_s[B-1:0];
   assign o_strb_hi = wide_s[2*B-1:B];

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit driving a valid/ready memory port, splitting or faulting misaligned accesses
module lsu
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_store,
   input  logic [2:0]              i_req_funct3,
   input  logic [31:0]             i_req_addr,
   input  logic [31:0]             i_req_wdata,
   output logic                    o_resp_valid,
   output logic [31:0]             o_resp_rdata,
   output logic                    o_resp_fault,
   output logic [31:0]             o_addr,
   output logic [DATA_WIDTH-1:0]   o_data,
   output logic [DATA_WIDTH/8-1:0] o_wstrb,
   output logic                    o_wr_valid,
   input  logic                    i_wr_ready,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic                    i_rd_valid,
   output logic                    o_rd_ready
);
   localparam int B = DATA_WIDTH / 8;
   localparam int OW = $clog2(B);

   lsu_state_t state_q, state_d;
   logic store_q, store_d, fault_q, fault_d, split_q, split_d;
   logic [2:0] f3_q, f3_d, req_size;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, base, ld_data;
   logic [DATA_WIDTH-1:0] rlo_q, rlo_d, rhi_q, rhi_d, data_lo, data_hi;
   logic [B-1:0] strb_lo, strb_hi;
   logic req_fault, req_split, beat, hs;

   always_comb begin
      req_size = size_bytes(i_req_funct3[1:0]);
      req_fault = (req_size == 3'd0) || (i_req_store && i_req_funct3[2]) ||
                  (!ALLOW_MISALIGNED && |(i_req_addr[2:0] & (req_size - 3'd1)));
      req_split = 4'(i_req_addr[OW-1:0]) + 4'(req_size) > 4'(B);
      hs = store_q ? i_wr_ready : i_rd_valid;
      state_d = state_q;
      store_d = store_q;
      fault_d = fault_q;
      split_d = split_q;
      f3_d = f3_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      rlo_d = rlo_q;
      rhi_d = rhi_q;
      case (state_q)
         IDLE: if (i_req_valid) begin
            store_d = i_req_store;
            fault_d = req_fault;
            split_d = req_split;
            f3_d = i_req_funct3;
            addr_d = i_req_addr;
            wdata_d = i_req_wdata;
            state_d = req_fault ? RESP : BEAT0;
         end
         BEAT0: if (hs) begin
            rlo_d = i_data;
            state_d = split_q ? BEAT1 : RESP;
         end
         BEAT1: if (hs) begin
            rhi_d = i_data;
            state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         store_q <= 1'b0;
         fault_q <= 1'b0;
         split_q <= 1'b0;
         f3_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         rlo_q <= '0;
         rhi_q <= '0;
      end else begin
         state_q <= state_d;
         store_q <= store_d;
         fault_q <= fault_d;
         split_q <= split_d;
         f3_q <= f3_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rlo_q <= rlo_d;
         rhi_q <= rhi_d;
      end
   end

   lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .i_size(f3_q[1:0]),
      .i_unsigned(f3_q[2]),
      .i_off(addr_q[OW-1:0]),
      .i_wdata(wdata_q),
      .i_rdata_lo(rlo_q),
      .i_rdata_hi(rhi_q),
      .o_data_lo(data_lo),
      .o_data_hi(data_hi),
      .o_strb_lo(strb_lo),
      .o_strb_hi(strb_hi),
      .o_rdata(ld_data)
   );

   always_comb begin
      beat = (state_q == BEAT0) || (state_q == BEAT1);
      base = addr_q & ~32'(B - 1);
      o_req_ready = (state_q == IDLE);
      o_resp_valid = (state_q == RESP);
      o_resp_fault = (state_q == RESP) && fault_q;
      o_resp_rdata = (state_q == RESP && !store_q && !fault_q) ? ld_data : '0;
      o_addr = !beat ? '0 : (state_q == BEAT1) ? base + 32'(B) : base;
      o_data = !(beat && store_q) ? '0 : (state_q == BEAT1) ? data_hi : data_lo;
      o_wstrb = !(beat && store_q) ? '0 : (state_q == BEAT1) ? strb_hi : strb_lo;
      o_wr_valid = beat && store_q;
      o_rd_ready = beat && !store_q;
   end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu across 32/64-bit buses and both alignment modes
module tb_lsu;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, req_v, store, wr_ready, rd_valid;
   logic [2:0] f3;
   logic [31:0] addr, wdata;
   int sel;
   logic [7:0] mem [256];

   logic rdy_a, rv_a, rf_a, wv_a, rr_a;
   logic [31:0] rd_a, ad_a, do_a, di_a;
   logic [3:0] ws_a;
   logic rdy_b, rv_b, rf_b, wv_b, rr_b;
   logic [31:0] rd_b, ad_b;
   logic [63:0] do_b, di_b;
   logic [7:0] ws_b;
   logic rdy_c, rv_c, rf_c, wv_c, rr_c;
   logic [31:0] rd_c, ad_c, do_c, di_c;
   logic [3:0] ws_c;

   function automatic logic [63:0] bus_rd(input logic [31:0] a);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[k*8 +: 8] = mem[8'(a[7:0] + 8'(k))];
      return r;
   endfunction

   assign di_a = 32'(bus_rd(ad_a));
   assign di_b = bus_rd(ad_b);
   assign di_c = 32'(bus_rd(ad_c));

   lsu #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) u_a (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_v && sel == 0), .o_req_ready(rdy_a),
      .i_req_store(store), .i_req_funct3(f3), .i_req_addr(addr), .i_req_wdata(wdata),
      .o_resp_valid(rv_a), .o_resp_rdata(rd_a), .o_resp_fault(rf_a), .o_addr(ad_a),
      .o_data(do_a), .o_wstrb(ws_a), .o_wr_valid(wv_a), .i_wr_ready(wr_ready),
      .i_data(di_a), .i_rd_valid(rd_valid), .o_rd_ready(rr_a));
   lsu #(.DATA_WIDTH(64), .ALLOW_MISALIGNED(1'b1)) u_b (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_v && sel == 1), .o_req_ready(rdy_b),
      .i_req_store(store), .i_req_funct3(f3), .i_req_addr(addr), .i_req_wdata(wdata),
      .o_resp_valid(rv_b), .o_resp_rdata(rd_b), .o_resp_fault(rf_b), .o_addr(ad_b),
      .o_data(do_b), .o_wstrb(ws_b), .o_wr_valid(wv_b), .i_wr_ready(wr_ready),
      .i_data(di_b), .i_rd_valid(rd_valid), .o_rd_ready(rr_b));
   lsu #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) u_c (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_v && sel == 2), .o_req_ready(rdy_c),
      .i_req_store(store), .i_req_funct3(f3), .i_req_addr(addr), .i_req_wdata(wdata),
      .o_resp_valid(rv_c), .o_resp_rdata(rd_c), .o_resp_fault(rf_c), .o_addr(ad_c),
      .o_data(do_c), .o_wstrb(ws_c), .o_wr_valid(wv_c), .i_wr_ready(wr_ready),
      .i_data(di_c), .i_rd_valid(rd_valid), .o_rd_ready(rr_c));

   logic c_rdy, c_rv, c_rf, c_wv, c_rr;
   logic [31:0] c_rd, c_ad;
   logic [63:0] c_do;
   logic [7:0] c_ws;
   always_comb begin
      c_rdy = (sel == 0) ? rdy_a : (sel == 1) ? rdy_b : rdy_c;
      c_rv = (sel == 0) ? rv_a : (sel == 1) ? rv_b : rv_c;
      c_rf = (sel == 0) ? rf_a : (sel == 1) ? rf_b : rf_c;
      c_wv = (sel == 0) ? wv_a : (sel == 1) ? wv_b : wv_c;
      c_rr = (sel == 0) ? rr_a : (sel == 1) ? rr_b : rr_c;
      c_rd = (sel == 0) ? rd_a : (sel == 1) ? rd_b : rd_c;
      c_ad = (sel == 0) ? ad_a : (sel == 1) ? ad_b : ad_c;
      c_do = (sel == 0) ? {32'h0, do_a} : (sel == 1) ? do_b : {32'h0, do_c};
      c_ws = (sel == 0) ? {4'h0, ws_a} : (sel == 1) ? ws_b : {4'h0, ws_c};
   end

   typedef struct {logic [31:0] rdata; logic fault; int lat;} exp_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0, errors = 0;
   logic [31:0] b_addr [2];
   logic [63:0] b_data [2];
   logic [7:0] b_strb [2];
   int nb, lat;
   logic bus_seen, got, g_f;
   logic [31:0] g_rd;

   // lat counts cycles from the accepting edge to the one showing o_resp_valid
   task automatic issue(input int s, input logic st, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd);
      sel = s;
      @(negedge clk);
      for (int i = 0; i < 50 && !c_rdy; i++) @(negedge clk);
      store = st; f3 = fn; addr = a; wdata = wd; req_v = 1'b1;
      nb = 0; bus_seen = 1'b0; got = 1'b0; lat = 0; g_rd = 'x; g_f = 1'bx;
      @(posedge clk);
      #1 req_v = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (c_wv || c_rr) bus_seen = 1'b1;
         if ((c_wv && wr_ready) || (c_rr && rd_valid)) begin
            if (nb < 2) begin
               b_addr[nb] = c_ad; b_data[nb] = c_do; b_strb[nb] = c_ws;
            end
            nb++;
         end
         if (c_rv) begin
            got = 1'b1; g_rd = c_rd; g_f = c_rf;
         end
      end
   endtask

   function automatic logic [31:0] ld_model(input logic [2:0] fn, input logic [31:0] a);
      logic [31:0] v;
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = mem[8'(a[7:0] + 8'(k))];
      case (fn)
         3'd0: return {{24{v[7]}}, v[7:0]};
         3'd1: return {{16{v[15]}}, v[15:0]};
         3'd4: return {24'h0, v[7:0]};
         3'd5: return {16'h0, v[15:0]};
         default: return v;
      endcase
   endfunction

   task automatic test_reset;
      rst = 1'b1; req_v = 1'b0; wr_ready = 1'b1; rd_valid = 1'b1; sel = 0;
      store = 1'b0; f3 = 3'd0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({rdy_a, rv_a, rf_a, wv_a, rr_a, rdy_b, rdy_c} !== 7'b1000011 || ad_a !== 0 || ws_a !== 0 || rd_a !== 0) begin
         errors++;
         $display("FAIL reset: ready/valids=%b addr=%h wstrb=%h rdata=%h, want 1000011/0/0/0",
                  {rdy_a, rv_a, rf_a, wv_a, rr_a, rdy_b, rdy_c}, ad_a, ws_a, rd_a);
      end
   endtask

   task automatic test_store_word;
      sb.push_back('{32'h0, 1'b0, 2});
      issue(0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
      e = sb.pop_front();
      checks++;
      if (!got || g_rd !== e.rdata || g_f !== e.fault || lat != e.lat) begin
         errors++;
         $display("FAIL sw_resp: got=%b rdata=%h fault=%b lat=%0d, want %h %b %0d", got, g_rd, g_f, lat, e.rdata, e.fault, e.lat);
      end
      checks++;
      if (nb != 1 || b_addr[0] !== 32'h100 || b_strb[0] !== 8'h0F || b_data[0] !== 64'hDEADBEEF) begin
         errors++;
         $display("FAIL sw_beat: beats=%0d addr=%h strb=%h data=%h, want 1 100 0f deadbeef", nb, b_addr[0], b_strb[0], b_data[0]);
      end
   endtask

   task automatic test_load_byte;
      mem[8'h00] = 8'h00; mem[8'h01] = 8'h00; mem[8'h02] = 8'h00; mem[8'h03] = 8'h80;
      sb.push_back('{32'hFFFFFF80, 1'b0, 2});
      issue(0, 1'b0, 3'd0, 32'h103, 32'h0);
      e = sb.pop_front();
      checks++;
      if (!got || g_rd !== e.rdata || g_f !== e.fault || lat != e.lat) begin
         errors++;
         $display("FAIL lb: got=%b rdata=%h fault=%b lat=%0d, want %h %b %0d", got, g_rd, g_f, lat, e.rdata, e.fault, e.lat);
      end
      sb.push_back('{32'h00000080, 1'b0, 2});
      issue(0, 1'b0, 3'd4, 32'h103, 32'h0);
      e = sb.pop_front();
      checks++;
      if (!got || g_rd !== e.rdata || g_f !== e.fault || lat != e.lat) begin
         errors++;
         $display("FAIL lbu: got=%b rdata=%h fault=%b lat=%0d, want %h %b %0d", got, g_rd, g_f, lat, e.rdata, e.fault, e.lat);
      end
   endtask

   task automatic test_split_load;
      mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
      mem[8'h04] = 8'h55; mem[8'h05] = 8'h66; mem[8'h06] = 8'h77; mem[8'h07] = 8'h88;
      sb.push_back('{32'h66554433, 1'b0, 3});
      issue(0, 1'b0, 3'd2, 32'h102, 32'h0);
      e = sb.pop_front();
      checks++;
      if (!got || g_rd !== e.rdata || g_f !== e.fault || lat != e.lat || nb != 2 || b_addr[0] !== 32'h100 || b_addr[1] !== 32'h104) begin
         errors++;
         $display("FAIL lw_split: got=%b rdata=%h lat=%0d beats=%0d addrs=%h,%h, want %h %0d 2 100,104",
                  got, g_rd, lat, nb, b_addr[0], b_addr[1], e.rdata, e.lat);
      end
      mem[8'hFF] = 8'h34; mem[8'h00] = 8'h92;
      sb.push_back('{32'hFFFF9234, 1'b0, 3});
      issue(0, 1'b0, 3'd1, 32'hFFFFFFFF, 32'h0);
      e = sb.pop_front();
      checks++;
      if (!got || g_rd !== e.rdata || lat != e.lat || nb != 2 || b_addr[0] !== 32'hFFFFFFFC || b_addr[1] !== 32'h0) begin
         errors++;
         $display("FAIL lh_wrap: got=%b rdata=%h lat=%0d beats=%0d addrs=%h,%h, want %h %0d 2 fffffffc,0",
                  got, g_rd, lat, nb, b_addr[0], b_addr[1], e.rdata, e.lat);
      end
   endtask

   task automatic test_split_store64;
      sb.push_back('{32'h0, 1'b0, 3});
      issue(1, 1'b1, 3'd1, 32'h7, 32'h0000ABCD);
      e = sb.pop_front();
      checks++;
      if (!got || g_rd !== e.rdata || g_f !== e.fault || lat != e.lat) begin
         errors++;
         $display("FAIL sh64_resp: got=%b rdata=%h fault=%b lat=%0d, want %h %b %0d", got, g_rd, g_f, lat, e.rdata, e.fault, e.lat);
      end
      checks++;
      if (nb != 2 || b_addr[0] !== 32'h0 || b_strb[0] !== 8'h80 || b_data[0][63:56] !== 8'hCD ||
          b_addr[1] !== 32'h8 || b_strb[1] !== 8'h01 || b_data[1][7:0] !== 8'hAB) begin
         errors++;
         $display("FAIL sh64_beats: n=%0d a0=%h s0=%h d0=%h a1=%h s1=%h d1=%h, want 2 0 80 cd.. 8 01 ..ab",
                  nb, b_addr[0], b_strb[0], b_data[0], b_addr[1], b_strb[1], b_data[1]);
      end
   endtask

   task automatic test_fault;
      sb.push_back('{32'h0, 1'b1, 1});
      issue(2, 1'b0, 3'd1, 32'h101, 32'h0);
      e = sb.pop_front();
      checks++;
      if (!got || g_rd !== e.rdata || g_f !== e.fault || lat != e.lat || bus_seen) begin
         errors++;
         $display("FAIL lh_misalign: got=%b rdata=%h fault=%b lat=%0d bus=%b, want %h %b %0d 0", got, g_rd, g_f, lat, bus_seen, e.rdata, e.fault, e.lat);
      end
      sb.push_back('{32'h0, 1'b1, 1});
      issue(2, 1'b0, 3'd3, 32'h100, 32'h0);
      e = sb.pop_front();
      checks++;
      if (!got || g_f !== e.fault || lat != e.lat || bus_seen) begin
         errors++;
         $display("FAIL f3_3: got=%b fault=%b lat=%0d bus=%b, want %b %0d 0", got, g_f, lat, bus_seen, e.fault, e.lat);
      end
      sb.push_back('{32'h0, 1'b1, 1});
      issue(0, 1'b1, 3'd4, 32'h100, 32'h12345678);
      e = sb.pop_front();
      checks++;
      if (!got || g_f !== e.fault || lat != e.lat || bus_seen) begin
         errors++;
         $display("FAIL store_f3_4: got=%b fault=%b lat=%0d bus=%b, want %b %0d 0", got, g_f, lat, bus_seen, e.fault, e.lat);
      end
      mem[8'h01] = 8'h7F; mem[8'h02] = 8'h01;
      sb.push_back('{32'h0000017F, 1'b0, 2});
      issue(0, 1'b0, 3'd1, 32'h101, 32'h0);
      e = sb.pop_front();
      checks++;
      if (!got || g_rd !== e.rdata || g_f !== e.fault || lat != e.lat) begin
         errors++;
         $display("FAIL lh_allow: got=%b rdata=%h fault=%b lat=%0d, want %h %b %0d", got, g_rd, g_f, lat, e.rdata, e.fault, e.lat);
      end
      sb.push_back('{ld_model(3'd2, 32'h104), 1'b0, 2});
      issue(2, 1'b0, 3'd2, 32'h104, 32'h0);
      e = sb.pop_front();
      checks++;
      if (!got || g_rd !== e.rdata || g_f !== e.fault || lat != e.lat) begin
         errors++;
         $display("FAIL lw_aligned_strict: got=%b rdata=%h fault=%b lat=%0d, want %h %b %0d", got, g_rd, g_f, lat, e.rdata, e.fault, e.lat);
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] fns [5];
      logic [2:0] fn;
      logic [31:0] a;
      int sz;
      fns = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 12; i++) begin
         fn = fns[$urandom_range(0, 4)];
         a = 32'h1000 + 32'($urandom_range(0, 255));
         sz = (fn[1:0] == 2'd0) ? 1 : (fn[1:0] == 2'd1) ? 2 : 4;
         sb.push_back('{ld_model(fn, a), 1'b0, (32'(a[2:0]) + sz > 8) ? 3 : 2});
         issue(1, 1'b0, fn, a, 32'h0);
         e = sb.pop_front();
         checks++;
         if (!got || g_rd !== e.rdata || g_f !== e.fault || lat != e.lat) begin
            errors++;
            $display("FAIL b2b[%0d] f3=%0d addr=%h: got=%b rdata=%h fault=%b lat=%0d, want %h %b %0d",
                     i, fn, a, got, g_rd, g_f, lat, e.rdata, e.fault, e.lat);
         end
      end
   endtask

   task automatic test_withhold_reset;
      int resp_seen;
      sel = 0; rd_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 50 && !rdy_a; i++) @(negedge clk);
      store = 1'b0; f3 = 3'd2; addr = 32'h100; req_v = 1'b1;
      @(posedge clk);
      #1 req_v = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (ad_a !== 32'h100 || rr_a !== 1'b1 || rv_a !== 1'b0) begin
            errors++;
            $display("FAIL withhold[%0d]: addr=%h rd_ready=%b resp=%b, want 100 1 0", i, ad_a, rr_a, rv_a);
         end
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (rr_a !== 1'b0 || rdy_a !== 1'b1 || rv_a !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: rd_ready=%b req_ready=%b resp=%b, want 0 1 0", rr_a, rdy_a, rv_a);
      end
      rd_valid = 1'b1;
      resp_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (rv_a || rr_a) resp_seen++;
      end
      checks++;
      if (resp_seen != 0) begin
         errors++;
         $display("FAIL post_reset: resp/read cycles=%0d, want 0", resp_seen);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_store_word();
      test_load_byte();
      test_split_load();
      test_split_store64();
      test_fault();
      test_back_to_back();
      test_withhold_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
